// File: rtl/arith_series_acc.sv
// Series accumulator: sums i*step or i*i for i < n.
// Loadable bound/step/mode, sticky overflow, start/busy/done handshake.
module arith_series_acc #(
   parameter int WIDTH        = 19,
   parameter int DEFAULT_N    = 150,
   parameter int DEFAULT_STEP = 1,
   parameter int AUTO_START   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   input  logic [WIDTH-1:0] step_in,
   input  logic             mode_in,
   output logic [WIDTH-1:0] i_out,
   output logic [WIDTH-1:0] sum_out,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam state_t RST_STATE =
      (AUTO_START != 0) ? RUN : IDLE;

   state_t state, state_nx;

   logic [WIDTH-1:0] i, n, step, sum;
   logic             mode, ovf_q;
   logic             load, advance;

   logic [2*WIDTH-1:0] wide_i, wide_step, term;
   logic [WIDTH:0]     add;

   always_ff @(posedge clk) begin
      if (rst) state <= RST_STATE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      advance  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = RUN;
               load     = 1'b1;
            end
         end
         RUN: begin
            if (i < n) advance  = 1'b1;
            else       state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Full-width product so the term overflow is visible.
   always_comb begin
      wide_i    = {{WIDTH{1'b0}}, i};
      wide_step = {{WIDTH{1'b0}}, step};
      term      = mode ? wide_i * wide_i
                       : wide_i * wide_step;
      add       = {1'b0, sum} + {1'b0, term[WIDTH-1:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i     <= '0;
         sum   <= '0;
         ovf_q <= 1'b0;
         n     <= WIDTH'(DEFAULT_N);
         step  <= WIDTH'(DEFAULT_STEP);
         mode  <= 1'b0;
      end else if (load) begin
         i     <= '0;
         sum   <= '0;
         ovf_q <= 1'b0;
         n     <= n_in;
         step  <= step_in;
         mode  <= mode_in;
      end else if (advance) begin
         i     <= i + 1'b1;
         sum   <= add[WIDTH-1:0];
         ovf_q <= ovf_q
                | (|term[2*WIDTH-1:WIDTH])
                | add[WIDTH];
      end
   end

   assign i_out   = i;
   assign sum_out = sum;
   assign ovf     = ovf_q;
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

endmodule
